// File: rtl/spu_fwd_scoreboard.sv
// Per-pipe result-latency scoreboard: forwards in-flight results to sources, stalls on unready producers.
// Optional: define SPU_FWD_STALL_CNT_EN to add a saturating 32-bit stall_cnt output.
module spu_fwd_scoreboard #(
  parameter int NUM_PIPES = 2,
  parameter int DEPTH     = 7,
  parameter int DATA_WD   = 128,
  parameter int ADDR_WD   = 7,
  parameter int NUM_SRC   = 3,
  parameter int LAT_WD    = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PIPES-1:0]                   iss_valid,
  input  logic [NUM_PIPES-1:0]                   iss_wr,
  input  logic [NUM_PIPES*ADDR_WD-1:0]           iss_rt_addr,
  input  logic [NUM_PIPES*LAT_WD-1:0]            iss_lat,
  input  logic [NUM_PIPES*NUM_SRC*ADDR_WD-1:0]   src_addr,
  input  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0]   rf_data,
  input  logic [NUM_PIPES*DEPTH*DATA_WD-1:0]     stg_data,
  output logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0]   fw_data,
  output logic                                   stall,
  output logic [NUM_PIPES-1:0]                   wb_en,
  output logic [NUM_PIPES*ADDR_WD-1:0]           wb_addr,
  output logic [NUM_PIPES*DATA_WD-1:0]           wb_data
`ifdef SPU_FWD_STALL_CNT_EN
  ,
  output logic [31:0]                            stall_cnt
`endif
);

  // Array index i holds stage i+1 (i cycles + 1 after issue).
  logic               v_r [NUM_PIPES][DEPTH];
  logic [ADDR_WD-1:0] a_r [NUM_PIPES][DEPTH];
  logic [LAT_WD-1:0]  l_r [NUM_PIPES][DEPTH];

  logic                 stall_s;
  logic                 hit_s;
  logic                 rdy_s;
  logic [DATA_WD-1:0]   sel_data_s;
  logic [NUM_PIPES-1:0] iss_acc_s;

  assign iss_acc_s = iss_valid & iss_wr & {NUM_PIPES{~stall_s}};
  assign stall     = stall_s;

  // Shift register: in-flight entries advance every cycle, even while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int s = 0; s < DEPTH; s++) begin
          v_r[p][s] <= 1'b0;
          a_r[p][s] <= {ADDR_WD{1'b0}};
          l_r[p][s] <= {LAT_WD{1'b0}};
        end
      end
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        v_r[p][0] <= iss_acc_s[p];
        a_r[p][0] <= iss_rt_addr[p*ADDR_WD +: ADDR_WD];
        l_r[p][0] <= iss_lat[p*LAT_WD +: LAT_WD];
        for (int s = 1; s < DEPTH; s++) begin
          v_r[p][s] <= v_r[p][s-1];
          a_r[p][s] <= a_r[p][s-1];
          l_r[p][s] <= l_r[p][s-1];
        end
      end
    end
  end

  // Youngest-match select per source: scan oldest-to-youngest so the last hit wins.
  always_comb begin
    stall_s    = 1'b0;
    fw_data    = rf_data;
    hit_s      = 1'b0;
    rdy_s      = 1'b0;
    sel_data_s = {DATA_WD{1'b0}};
    for (int p = 0; p < NUM_PIPES; p++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        hit_s      = 1'b0;
        rdy_s      = 1'b0;
        sel_data_s = {DATA_WD{1'b0}};
        for (int s = DEPTH - 1; s >= 0; s--) begin
          for (int q = 0; q < NUM_PIPES; q++) begin
            if (v_r[q][s] && (a_r[q][s] == src_addr[(p*NUM_SRC+k)*ADDR_WD +: ADDR_WD])) begin
              hit_s      = 1'b1;
              rdy_s      = (LAT_WD'(s + 1) >= l_r[q][s]);
              sel_data_s = stg_data[(q*DEPTH+s)*DATA_WD +: DATA_WD];
            end else begin
              hit_s      = hit_s;
            end
          end
        end
        if (hit_s && rdy_s) begin
          fw_data[(p*NUM_SRC+k)*DATA_WD +: DATA_WD] = sel_data_s;
        end else if (hit_s && iss_valid[p]) begin
          stall_s = 1'b1;
        end else begin
          stall_s = stall_s;
        end
      end
    end
  end

  // Writeback from the last stage; address and data are zeroed when no entry leaves.
  always_comb begin
    wb_en   = {NUM_PIPES{1'b0}};
    wb_addr = {(NUM_PIPES*ADDR_WD){1'b0}};
    wb_data = {(NUM_PIPES*DATA_WD){1'b0}};
    for (int p = 0; p < NUM_PIPES; p++) begin
      wb_en[p] = v_r[p][DEPTH-1];
      if (v_r[p][DEPTH-1]) begin
        wb_addr[p*ADDR_WD +: ADDR_WD] = a_r[p][DEPTH-1];
        wb_data[p*DATA_WD +: DATA_WD] = stg_data[(p*DEPTH+DEPTH-1)*DATA_WD +: DATA_WD];
      end else begin
        wb_addr[p*ADDR_WD +: ADDR_WD] = {ADDR_WD{1'b0}};
        wb_data[p*DATA_WD +: DATA_WD] = {DATA_WD{1'b0}};
      end
    end
  end

`ifdef SPU_FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_spu_fwd_scoreboard.sv
// Directed self-checking bench for spu_fwd_scoreboard (stall_cnt test under SPU_FWD_STALL_CNT_EN).
module tb_spu_fwd_scoreboard;
  localparam int NP = 2;
  localparam int DP = 7;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int NS = 3;
  localparam int LW = 3;

  logic                   clk;
  logic                   rst;
  logic [NP-1:0]          iss_valid;
  logic [NP-1:0]          iss_wr;
  logic [NP*AW-1:0]       iss_rt_addr;
  logic [NP*LW-1:0]       iss_lat;
  logic [NP*NS*AW-1:0]    src_addr;
  logic [NP*NS*DW-1:0]    rf_data;
  logic [NP*DP*DW-1:0]    stg_data;
  logic [NP*NS*DW-1:0]    fw_data;
  logic                   stall;
  logic [NP-1:0]          wb_en;
  logic [NP*AW-1:0]       wb_addr;
  logic [NP*DW-1:0]       wb_data;
`ifdef SPU_FWD_STALL_CNT_EN
  logic [31:0]            stall_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;

  spu_fwd_scoreboard dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wr(iss_wr),
    .iss_rt_addr(iss_rt_addr), .iss_lat(iss_lat), .src_addr(src_addr),
    .rf_data(rf_data), .stg_data(stg_data), .fw_data(fw_data), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef SPU_FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] stgv(input int p, input int s);
    return {32'hC0DE_0000, p[31:0], s[31:0], 32'h5A5A_A5A5};
  endfunction

  function automatic logic [DW-1:0] rfv(input int idx);
    return {32'hBEEF_0000, idx[31:0], 64'h0123_4567_89AB_CDEF};
  endfunction

  function automatic logic [DW-1:0] fw(input int p, input int k);
    return fw_data[(p*NS+k)*DW +: DW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    iss_valid   = '0;
    iss_wr      = '0;
    iss_rt_addr = '0;
    iss_lat     = '0;
    for (int i = 0; i < NP*NS; i++) src_addr[i*AW +: AW] = AW'(100 + i);
  endtask

  task automatic issue(input int p, input logic wr, input int addr, input int lat);
    iss_valid[p]              = 1'b1;
    iss_wr[p]                 = wr;
    iss_rt_addr[p*AW +: AW]   = AW'(addr);
    iss_lat[p*LW +: LW]       = LW'(lat);
  endtask

  task automatic set_src(input int p, input int k, input int addr);
    src_addr[(p*NS+k)*AW +: AW] = AW'(addr);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    clear_inputs();
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    iss_valid = 2'b11;
    iss_wr    = 2'b11;
    issue(0, 1'b1, 5, 1);
    issue(1, 1'b1, 5, 1);
    set_src(0, 0, 5);
    set_src(1, 2, 5);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (wb_en !== 2'b00) $display("FAIL reset_wb_en: got %b want 00", wb_en); else pass_cnt++;
    total++; if (wb_addr !== '0) $display("FAIL reset_wb_addr: got %h want 0", wb_addr); else pass_cnt++;
    total++; if (wb_data !== '0) $display("FAIL reset_wb_data: got %h want 0", wb_data); else pass_cnt++;
    total++; if (fw_data !== rf_data) $display("FAIL reset_fw: got %h want %h", fw(0,0), rfv(0)); else pass_cnt++;
    tick();
    tick();
    total++; if (stall !== 1'b0) $display("FAIL reset_hold_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (wb_en !== 2'b00) $display("FAIL reset_hold_wb_en: got %b want 00", wb_en); else pass_cnt++;
    total++; if (fw_data !== rf_data) $display("FAIL reset_hold_fw: got %h want %h", fw(0,0), rfv(0)); else pass_cnt++;
    rst = 1'b1;
    clear_inputs();
    #1;
    total++; if (fw_data !== rf_data) $display("FAIL reset_release_fw: got %h want %h", fw(0,0), rfv(0)); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    issue(0, 1'b1, 5, 2);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL b2b_issue_stall: got %b want 0", stall); else pass_cnt++;
    tick();
    clear_inputs();
    set_src(1, 0, 5);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL b2b_gated_stall: got %b want 0", stall); else pass_cnt++;
    issue(1, 1'b1, 40, 1);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL b2b_stall: got %b want 1", stall); else pass_cnt++;
    tick();
    clear_inputs();
    iss_valid[1] = 1'b1;
    set_src(1, 0, 5);
    set_src(1, 1, 40);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL b2b_ready_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (fw(1,0) !== stgv(0,2)) $display("FAIL b2b_fw: got %h want %h", fw(1,0), stgv(0,2)); else pass_cnt++;
    total++; if (fw(1,1) !== rfv(4)) $display("FAIL b2b_blocked_issue: got %h want %h", fw(1,1), rfv(4)); else pass_cnt++;
    repeat (5) tick();
    total++; if (wb_en !== 2'b01) $display("FAIL b2b_wb_en: got %b want 01", wb_en); else pass_cnt++;
    total++; if (wb_addr[AW-1:0] !== 7'd5) $display("FAIL b2b_wb_addr: got %0d want 5", wb_addr[AW-1:0]); else pass_cnt++;
    total++; if (wb_data[DW-1:0] !== stgv(0,7)) $display("FAIL b2b_wb_data: got %h want %h", wb_data[DW-1:0], stgv(0,7)); else pass_cnt++;
    total++; if (fw(1,0) !== stgv(0,7)) $display("FAIL b2b_fw_s7: got %h want %h", fw(1,0), stgv(0,7)); else pass_cnt++;
  endtask

  task automatic test_waw;
    do_reset();
    issue(0, 1'b1, 9, 1);
    tick();
    clear_inputs();
    issue(1, 1'b1, 9, 6);
    tick();
    clear_inputs();
    iss_valid[0] = 1'b1;
    set_src(0, 0, 9);
    #1;
    for (int n = 1; n <= 5; n++) begin
      total++; if (stall !== 1'b1) $display("FAIL waw_stall_s%0d: got %b want 1", n, stall); else pass_cnt++;
      total++; if (fw(0,0) === stgv(0,n+1)) $display("FAIL waw_old_fw_s%0d: got %h want not pipe0 data", n, fw(0,0)); else pass_cnt++;
      tick();
    end
    total++; if (stall !== 1'b0) $display("FAIL waw_release_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (fw(0,0) !== stgv(1,6)) $display("FAIL waw_fw: got %h want %h", fw(0,0), stgv(1,6)); else pass_cnt++;
    total++; if (wb_en !== 2'b01) $display("FAIL waw_wb_en: got %b want 01", wb_en); else pass_cnt++;
  endtask

  task automatic test_wb_bypass;
    do_reset();
    issue(0, 1'b1, 3, 7);
    tick();
    clear_inputs();
    repeat (6) tick();
    iss_valid[0] = 1'b1;
    set_src(0, 1, 3);
    #1;
    total++; if (wb_en !== 2'b01) $display("FAIL wbb_wb_en: got %b want 01", wb_en); else pass_cnt++;
    total++; if (wb_addr[AW-1:0] !== 7'd3) $display("FAIL wbb_wb_addr: got %0d want 3", wb_addr[AW-1:0]); else pass_cnt++;
    total++; if (wb_data[DW-1:0] !== stgv(0,7)) $display("FAIL wbb_wb_data: got %h want %h", wb_data[DW-1:0], stgv(0,7)); else pass_cnt++;
    total++; if (fw(0,1) !== stgv(0,7)) $display("FAIL wbb_fw: got %h want %h", fw(0,1), stgv(0,7)); else pass_cnt++;
    total++; if (stall !== 1'b0) $display("FAIL wbb_stall: got %b want 0", stall); else pass_cnt++;
    tick();
    total++; if (wb_en !== 2'b00) $display("FAIL wbb_gone_wb_en: got %b want 00", wb_en); else pass_cnt++;
    total++; if (wb_data !== '0) $display("FAIL wbb_gone_wb_data: got %h want 0", wb_data); else pass_cnt++;
    total++; if (fw(0,1) !== rfv(1)) $display("FAIL wbb_gone_fw: got %h want %h", fw(0,1), rfv(1)); else pass_cnt++;
  endtask

  task automatic test_tie;
    do_reset();
    issue(0, 1'b1, 12, 1);
    issue(1, 1'b1, 12, 1);
    tick();
    clear_inputs();
    iss_valid[0] = 1'b1;
    set_src(0, 2, 12);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL tie_stall: got %b want 0", stall); else pass_cnt++;
    total++; if (fw(0,2) !== stgv(1,1)) $display("FAIL tie_fw_s1: got %h want %h", fw(0,2), stgv(1,1)); else pass_cnt++;
    tick();
    total++; if (fw(0,2) !== stgv(1,2)) $display("FAIL tie_fw_s2: got %h want %h", fw(0,2), stgv(1,2)); else pass_cnt++;
  endtask

  task automatic test_no_write;
    do_reset();
    issue(0, 1'b0, 20, 3);
    set_src(0, 0, 20);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL nowr_stall0: got %b want 0", stall); else pass_cnt++;
    tick();
    total++; if (stall !== 1'b0) $display("FAIL nowr_stall1: got %b want 0", stall); else pass_cnt++;
    total++; if (fw(0,0) !== rfv(0)) $display("FAIL nowr_fw: got %h want %h", fw(0,0), rfv(0)); else pass_cnt++;
    clear_inputs();
    repeat (6) tick();
    total++; if (wb_en !== 2'b00) $display("FAIL nowr_wb_en: got %b want 00", wb_en); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    issue(0, 1'b1, 5, 1);
    tick();
    clear_inputs();
    tick();
    set_src(0, 0, 5);
    #1;
    total++; if (fw(0,0) !== stgv(0,2)) $display("FAIL rmid_pre_fw: got %h want %h", fw(0,0), stgv(0,2)); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++; if (fw(0,0) !== rfv(0)) $display("FAIL rmid_fw: got %h want %h", fw(0,0), rfv(0)); else pass_cnt++;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (wb_en !== 2'b00) $display("FAIL rmid_wb_en_%0d: got %b want 00", i, wb_en); else pass_cnt++;
    end
  endtask

`ifdef SPU_FWD_STALL_CNT_EN
  task automatic test_stall_cnt;
    do_reset();
    total++; if (stall_cnt !== 32'd0) $display("FAIL cnt_init: got %0d want 0", stall_cnt); else pass_cnt++;
    issue(0, 1'b1, 5, 5);
    tick();
    clear_inputs();
    iss_valid[1] = 1'b1;
    set_src(1, 0, 5);
    #1;
    repeat (4) tick();
    total++; if (stall !== 1'b0) $display("FAIL cnt_stall_end: got %b want 0", stall); else pass_cnt++;
    total++; if (stall_cnt !== 32'd4) $display("FAIL cnt_four: got %0d want 4", stall_cnt); else pass_cnt++;
    tick();
    total++; if (stall_cnt !== 32'd4) $display("FAIL cnt_hold: got %0d want 4", stall_cnt); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd0) $display("FAIL cnt_reset: got %0d want 0", stall_cnt); else pass_cnt++;
    rst = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int s = 1; s <= DP; s++) stg_data[(p*DP+s-1)*DW +: DW] = stgv(p, s);
    for (int i = 0; i < NP*NS; i++) rf_data[i*DW +: DW] = rfv(i);
    clear_inputs();
    #2;
    test_reset();
    test_back_to_back();
    test_waw();
    test_wb_bypass();
    test_tie();
    test_no_write();
    test_reset_mid();
`ifdef SPU_FWD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
